// File: rtl/pe2_lsb_pkg.sv
// ============================================================================
// Module      : pe2_lsb_pkg
// Description : Shared constants for the two-deep LSB-first priority encoder.
//               There are no typedefs. The package holds the default and
//               minimum request widths so that the top module and the
//               sub-module agree on them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe2_lsb_pkg;

    // Default number of request bits.
    localparam int unsigned C_PE2_DEFAULT_WIDTH = 8;

    // A two-deep encoder needs at least two request bits to be meaningful.
    localparam int unsigned C_PE2_MIN_WIDTH     = 2;

endpackage : pe2_lsb_pkg

`default_nettype wire

// File: rtl/pe2_lsb_pe.sv
// ============================================================================
// Module      : pe_lsb
// Description : Single-level, combinational LSB-first priority encoder.
//               Bit 0 has the highest priority.
//   Ports:
//     req_vec     [WIDTH-1:0]          request vector
//     ack_one_hot [WIDTH-1:0]          isolated lowest set bit (0 if none)
//     ack_index   [$clog2(WIDTH)-1:0]  binary index of that bit (0 if none)
//     found                            at least one request bit is set
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_lsb
    import pe2_lsb_pkg::*;
#(
    parameter int unsigned WIDTH = C_PE2_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]         req_vec,
    output logic [WIDTH-1:0]         ack_one_hot,
    output logic [$clog2(WIDTH)-1:0] ack_index,
    output logic                     found
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] w_one_hot;
    logic [IDX_W-1:0] w_index;

    // Two's-complement trick: req & -req keeps only the lowest set bit.
    // The result is zero when req is zero.
    assign w_one_hot = req_vec & (~req_vec + {{(WIDTH-1){1'b0}}, 1'b1});

    // OR-reduce the indices of the (at most one) set bit. For a
    // non-power-of-two WIDTH, the unused index codes are simply never
    // produced. A zero vector encodes to index 0.
    always_comb begin
        w_index = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (w_one_hot[i]) begin
                w_index = w_index | IDX_W'(i);
            end
        end
    end

    assign ack_one_hot = w_one_hot;
    assign ack_index   = w_index;
    assign found       = |req_vec;

endmodule : pe_lsb

`default_nettype wire

// File: rtl/pe2_lsb.sv
// ============================================================================
// Module      : pe2_lsb
// Description : Registered two-deep LSB-first priority encoder. Reports the
//               second-lowest set bit of req_vec as a one-hot vector and a
//               binary index. Also reports whether at least one and at least
//               two request bits are set.
//   Parameters:
//     WIDTH (>= 2)  number of request bits
//   Ports:
//     CLK                               clock, rising edge
//     RST                               synchronous reset, active-high
//     req_vec      [WIDTH-1:0]          request vector, bit 0 highest priority
//     ack_one_hot  [WIDTH-1:0]          one-hot of second-lowest set bit
//     ack_index    [$clog2(WIDTH)-1:0]  index of that bit (0 if < 2 set)
//     found_first                       req_vec has >= 1 bit set
//     found_second                      req_vec has >= 2 bits set
//   Build option:
//     PE2_LSB_COMB_OUT_EN  when defined, the output registers are removed.
//                          Outputs then follow req_vec combinationally with
//                          zero latency, and CLK and RST are unused.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe2_lsb
    import pe2_lsb_pkg::*;
#(
    parameter int unsigned WIDTH = C_PE2_DEFAULT_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         req_vec,
    output logic [WIDTH-1:0]         ack_one_hot,
    output logic [$clog2(WIDTH)-1:0] ack_index,
    output logic                     found_first,
    output logic                     found_second
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] w_first_oh;
    logic [IDX_W-1:0] w_unused_first_idx;   // first grant is encoded elsewhere
    logic             w_found_first;
    logic [WIDTH-1:0] w_rem_vec;
    logic [WIDTH-1:0] w_second_oh;
    logic [IDX_W-1:0] w_second_idx;
    logic             w_found_second;

    // Stage 1: lowest set bit of the raw request vector.
    pe_lsb #(
        .WIDTH       (WIDTH)
    ) u_first (
        .req_vec     (req_vec),
        .ack_one_hot (w_first_oh),
        .ack_index   (w_unused_first_idx),
        .found       (w_found_first)
    );

    // Stage 2: mask off the first winner. The lowest remaining bit is the
    // second grant. "found" on the masked vector means two or more requests.
    assign w_rem_vec = req_vec & ~w_first_oh;

    pe_lsb #(
        .WIDTH       (WIDTH)
    ) u_second (
        .req_vec     (w_rem_vec),
        .ack_one_hot (w_second_oh),
        .ack_index   (w_second_idx),
        .found       (w_found_second)
    );

`ifdef PE2_LSB_COMB_OUT_EN

    // CLK and RST stay on the port list so that both builds are pin-compatible.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = CLK ^ RST;

    assign ack_one_hot  = w_second_oh;
    assign ack_index    = w_second_idx;
    assign found_first  = w_found_first;
    assign found_second = w_found_second;

`else

    logic [WIDTH-1:0] r_ack_one_hot;
    logic [IDX_W-1:0] r_ack_index;
    logic             r_found_first;
    logic             r_found_second;

    // Reset takes priority over req_vec. A result that is pending when RST
    // is asserted is discarded.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ack_one_hot  <= '0;
            r_ack_index    <= '0;
            r_found_first  <= 1'b0;
            r_found_second <= 1'b0;
        end else begin
            r_ack_one_hot  <= w_second_oh;
            r_ack_index    <= w_second_idx;
            r_found_first  <= w_found_first;
            r_found_second <= w_found_second;
        end
    end

    assign ack_one_hot  = r_ack_one_hot;
    assign ack_index    = r_ack_index;
    assign found_first  = r_found_first;
    assign found_second = r_found_second;

`endif

endmodule : pe2_lsb

`default_nettype wire

// File: tb/tb_pe2_lsb.sv
// ============================================================================
// Module      : tb_pe2_lsb
// Description : Self-checking testbench for pe2_lsb. It uses a WIDTH=8
//               instance for the main checks and a WIDTH=5 instance for the
//               non-power-of-two case. Expected results are pushed to a
//               scoreboard queue when stimulus is driven, then popped and
//               compared after the capturing edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe2_lsb;

    typedef struct packed {
        logic [7:0] oh;
        logic [2:0] idx;
        logic       ff;
        logic       fs;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic [7:0] req_vec;
    logic [7:0] ack_one_hot;
    logic [2:0] ack_index;
    logic       found_first;
    logic       found_second;

    logic [4:0] req5;
    logic [4:0] oh5;
    logic [2:0] idx5;
    logic       ff5;
    logic       fs5;

    int   tests;
    int   fails;
    exp_t sb[$];

    pe2_lsb #(.WIDTH(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_vec      (req_vec),
        .ack_one_hot  (ack_one_hot),
        .ack_index    (ack_index),
        .found_first  (found_first),
        .found_second (found_second)
    );

    pe2_lsb #(.WIDTH(5)) dut5 (
        .CLK          (CLK),
        .RST          (RST),
        .req_vec      (req5),
        .ack_one_hot  (oh5),
        .ack_index    (idx5),
        .found_first  (ff5),
        .found_second (fs5)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: walk the bits in priority order and count the set
    // ones. The second set bit found is the expected grant.
    function automatic exp_t model8(input logic [7:0] v, input logic r);
        exp_t e;
        int   n;
        e = '0;
        n = 0;
        if (!r) begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) begin
                    n++;
                    if (n == 2) begin
                        e.oh[i] = 1'b1;
                        e.idx   = 3'(i);
                    end
                end
            end
            e.ff = (n >= 1);
            e.fs = (n >= 2);
        end
        return e;
    endfunction

    // Drive one input vector and reset value, push the model's expectation,
    // and advance past the capturing edge to a sample point away from it.
    task automatic cycle(input logic [7:0] v, input logic r);
        req_vec = v;
        RST     = r;
        sb.push_back(model8(v, r));
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        cycle(8'hFF, 1'b1);
        e = sb.pop_front();
        tests++;
        if ({ack_one_hot, ack_index, found_first, found_second} !== {e.oh, e.idx, e.ff, e.fs}
            || e !== '0) begin
            fails++;
            $display("FAIL reset_dominates: got %b/%0d/%b/%b want 0/0/0/0",
                     ack_one_hot, ack_index, found_first, found_second);
        end
        cycle(8'h00, 1'b0);
        e = sb.pop_front();
        tests++;
        if ({ack_one_hot, ack_index, found_first, found_second} !== {e.oh, e.idx, e.ff, e.fs}) begin
            fails++;
            $display("FAIL reset_release_zero: got %b/%0d/%b/%b want %b/%0d/%b/%b",
                     ack_one_hot, ack_index, found_first, found_second, e.oh, e.idx, e.ff, e.fs);
        end
    endtask

    task automatic test_exhaustive();
        exp_t e;
        for (int v = 0; v < 256; v++) begin
            cycle(8'(v), 1'b0);
            e = sb.pop_front();
            tests++;
            if ({ack_one_hot, ack_index, found_first, found_second} !== {e.oh, e.idx, e.ff, e.fs}) begin
                fails++;
                $display("FAIL exhaustive req=%b: got %b/%0d/%b/%b want %b/%0d/%b/%b",
                         8'(v), ack_one_hot, ack_index, found_first, found_second,
                         e.oh, e.idx, e.ff, e.fs);
            end
            tests++;
            if ($countones(ack_one_hot) > 1 || (found_second && !found_first)
                || ((ack_one_hot != 8'h00) != found_second)) begin
                fails++;
                $display("FAIL invariant req=%b: got oh=%b ff=%b fs=%b want onehot0 fs->ff oh!=0==fs",
                         8'(v), ack_one_hot, found_first, found_second);
            end
        end
    endtask

    task automatic test_example();
        exp_t e;
        cycle(8'b0010_1100, 1'b0);
        e = sb.pop_front();
        tests++;
        if ({ack_one_hot, ack_index, found_first, found_second} !== {8'b0000_1000, 3'd3, 1'b1, 1'b1}
            || e !== {8'b0000_1000, 3'd3, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL example_2c: got %b/%0d/%b/%b want 00001000/3/1/1",
                     ack_one_hot, ack_index, found_first, found_second);
        end
    endtask

    task automatic test_single_bit();
        exp_t e;
        cycle(8'b1000_0000, 1'b0);
        e = sb.pop_front();
        tests++;
        if ({ack_one_hot, ack_index, found_first, found_second} !== {8'h00, 3'd0, 1'b1, 1'b0}
            || e !== {8'h00, 3'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL single_bit: got %b/%0d/%b/%b want 00000000/0/1/0",
                     ack_one_hot, ack_index, found_first, found_second);
        end
    endtask

    task automatic test_extremes();
        exp_t e;
        cycle(8'b1100_0000, 1'b0);
        e = sb.pop_front();
        tests++;
        if ({ack_one_hot, ack_index, found_first, found_second} !== {8'b1000_0000, 3'd7, 1'b1, 1'b1}
            || e !== {8'b1000_0000, 3'd7, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL top_two: got %b/%0d/%b/%b want 10000000/7/1/1",
                     ack_one_hot, ack_index, found_first, found_second);
        end
        cycle(8'hFF, 1'b0);
        e = sb.pop_front();
        tests++;
        if ({ack_one_hot, ack_index, found_first, found_second} !== {8'b0000_0010, 3'd1, 1'b1, 1'b1}
            || e !== {8'b0000_0010, 3'd1, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL all_ones: got %b/%0d/%b/%b want 00000010/1/1/1",
                     ack_one_hot, ack_index, found_first, found_second);
        end
    endtask

    task automatic test_back_to_back_reset();
        exp_t e;
        cycle(8'b0000_0110, 1'b0);
        e = sb.pop_front();
        tests++;
        if ({ack_one_hot, ack_index, found_first, found_second} !== {8'b0000_0100, 3'd2, 1'b1, 1'b1}
            || e !== {8'b0000_0100, 3'd2, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL latency_06: got %b/%0d/%b/%b want 00000100/2/1/1",
                     ack_one_hot, ack_index, found_first, found_second);
        end
        cycle(8'b0000_0110, 1'b1);
        e = sb.pop_front();
        tests++;
        if ({ack_one_hot, ack_index, found_first, found_second} !== {e.oh, e.idx, e.ff, e.fs}
            || e !== '0) begin
            fails++;
            $display("FAIL mid_reset: got %b/%0d/%b/%b want 0/0/0/0",
                     ack_one_hot, ack_index, found_first, found_second);
        end
        cycle(8'b0000_0011, 1'b0);
        e = sb.pop_front();
        tests++;
        if ({ack_one_hot, ack_index, found_first, found_second} !== {8'b0000_0010, 3'd1, 1'b1, 1'b1}
            || e !== {8'b0000_0010, 3'd1, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL post_reset_03: got %b/%0d/%b/%b want 00000010/1/1/1",
                     ack_one_hot, ack_index, found_first, found_second);
        end
    endtask

    task automatic test_width5();
        req5 = 5'b10100;
        RST  = 1'b0;
        @(posedge CLK);
        #1;
        tests++;
        if ({oh5, idx5, ff5, fs5} !== {5'b10000, 3'd4, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL width5_10100: got %b/%0d/%b/%b want 10000/4/1/1",
                     oh5, idx5, ff5, fs5);
        end
        req5 = 5'b00001;
        @(posedge CLK);
        #1;
        tests++;
        if ({oh5, idx5, ff5, fs5} !== {5'b00000, 3'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL width5_00001: got %b/%0d/%b/%b want 00000/0/1/0",
                     oh5, idx5, ff5, fs5);
        end
        req5 = 5'b11000;
        @(posedge CLK);
        #1;
        tests++;
        if ({oh5, idx5, ff5, fs5} !== {5'b10000, 3'd4, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL width5_11000: got %b/%0d/%b/%b want 10000/4/1/1",
                     oh5, idx5, ff5, fs5);
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        RST     = 1'b1;
        req_vec = 8'h00;
        req5    = 5'b00000;
        @(negedge CLK);

        test_reset();
        test_exhaustive();
        test_example();
        test_single_bit();
        test_extremes();
        test_back_to_back_reset();
        test_width5();

        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_pe2_lsb

`default_nettype wire

// File: doc/pe2_lsb.md
Name: pe2_lsb

Overview:
- Registered two-deep LSB-first priority encoder.
- Finds the lowest and second-lowest set bits of a request vector.
- Reports the second-lowest as a one-hot vector and a binary index, plus flags for whether at least one and at least two requests are set.
- Used in core allocation and select paths that grant two requesters per cycle. The first grant is derived separately by a plain LSB encoder; this block supplies the second grant and both found flags.

Parameters:
- WIDTH, default 8: number of request bits; must be >= 2. Index width is $clog2(WIDTH).

Ports:
- CLK, input, 1: clock; all state updates on the rising edge.
- RST, input, 1: synchronous reset, active-high.
- req_vec, input, WIDTH: request vector; bit 0 has highest priority.
- ack_one_hot, output, WIDTH: one-hot position of the second-lowest set bit of req_vec; all zeros if fewer than two bits are set.
- ack_index, output, $clog2(WIDTH): binary index of the same bit; 0 if fewer than two bits are set.
- found_first, output, 1: req_vec has at least one bit set.
- found_second, output, 1: req_vec has at least two bits set.

Behaviour:
- Combinational core:
  - first = req_vec & -req_vec (lowest set bit).
  - rem = req_vec & ~first.
  - second = rem & -rem.
  - found_first = |req_vec; found_second = |rem.
  - second_index = binary encode of second.
- All four outputs are registered: value sampled from req_vec at rising edge N appears after edge N, i.e. 1-cycle latency.
- Reset:
  - RST=1 at a rising edge forces ack_one_hot=0, ack_index=0, found_first=0, found_second=0.
  - Reset dominates req_vec.
  - Mid-operation reset discards the pending result.
  - First valid result is produced the edge after RST deasserts.
- Boundaries:
  - req_vec=0: all outputs 0.
  - Exactly one bit set: found_first=1, found_second=0, ack_one_hot=0, ack_index=0.
  - All ones: ack_one_hot = bit 1 set, ack_index=1, both flags 1.
  - Only the top two bits set: ack index WIDTH-1.
- Invariants:
  - ack_one_hot is zero or exactly one-hot.
  - found_second implies found_first.
  - ack_one_hot != 0 exactly when found_second.
  - ack_index equals the position of ack_one_hot when nonzero.
- Must work for non-power-of-two WIDTH; index encode ignores unused codes.
- No X propagation: outputs are fully defined for any 0/1 input.

Optional Feature:
- Macro: PE2_LSB_COMB_OUT_EN.
- Defined: output registers are removed. Outputs follow req_vec combinationally with zero latency, and CLK/RST stay as ports but are unused.
- Undefined (default): registered outputs with 1-cycle latency and synchronous reset, as specified above.

Decomposition:
- No shared-package typedefs required.
- WIDTH stays a local parameter; the index width is derived with $clog2 inside the module.
- One sub-module is natural: pe_lsb (WIDTH param; req_vec in; ack_one_hot, ack_index, found out), a single-level LSB priority encoder. Instantiate it twice:
  - first on req_vec;
  - second on req_vec masked by the first instance's one-hot.
- Output flops sit in pe2_lsb.

Test Plan:
- Reset: RST=1, req_vec=8'b11111111, one edge -> all outputs 0. Deassert with req_vec=0 -> outputs stay 0.
- Exhaustive: all 256 values of req_vec (WIDTH=8), one per cycle, compared against a reference model one cycle later. Example: 8'b00101100 -> ack_one_hot=8'b00001000, ack_index=3, found_first=1, found_second=1.
- Single bit: req_vec=8'b10000000 -> ack_one_hot=0, ack_index=0, found_first=1, found_second=0.
- Extremes:
  - 8'b11000000 -> ack_one_hot=8'b10000000, ack_index=7, flags 1/1.
  - 8'b11111111 -> ack_one_hot=8'b00000010, ack_index=1.
- Latency/reset mid-stream:
  - Apply 8'b00000110; on the next edge assert RST -> after the first edge outputs are 00000100/2/1/1, after the reset edge all 0.
  - Release RST with 8'b00000011 -> 00000010/1/1/1.
- Parameter sweep: WIDTH=5 with req_vec=5'b10100 -> ack_one_hot=5'b10000, ack_index=4, flags 1/1.
